// File: rtl/mac_sat_sequencer_if.sv
// Tap-input and result-output streams of the saturating MAC sequencer.
interface mac_sat_sequencer_if #(
    parameter int WORD_SIZE = 16
) ();
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WORD_SIZE-1:0] data_i;
    logic [WORD_SIZE-1:0] weight_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [WORD_SIZE-1:0] out_data_o;

    modport master (
        output in_valid_i, data_i, weight_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  in_valid_i, data_i, weight_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/mac_sat_sequencer.sv
// Saturating fixed-point dot-product sequencer: NUM_TAPS beats in, one result out,
// with per-beat saturation pulses and first-event-wins sticky flags.
module mac_sat_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int INT_BITS  = 8,
    parameter int NUM_TAPS  = 9
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 abort_i,
    input  logic                 clear_flags_i,
    mac_sat_sequencer_if.slave   bus,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic                 overflow_flag_o,
    output logic                 underflow_flag_o
);
    localparam int FRAC_BITS = WORD_SIZE - INT_BITS;
    localparam int CNT_W     = $clog2(NUM_TAPS + 1);
    localparam logic [WORD_SIZE-1:0] SAT_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic [WORD_SIZE-1:0] SAT_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t               state_q;
    logic [WORD_SIZE-1:0] acc_q;
    logic [CNT_W-1:0]     count_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WORD_SIZE-1:0] out_data_q;
    logic                 ovf_pulse_q, unf_pulse_q;
    logic                 ovf_flag_q, unf_flag_q;

    logic signed [2*WORD_SIZE-1:0] prod_full, prod_shift;
    logic [WORD_SIZE:0]            hi_bits;
    logic                          prod_pos, prod_neg;
    logic [WORD_SIZE-1:0]          prod_sat;
    logic [WORD_SIZE:0]            sum;
    logic                          add_pos, add_neg;
    logic [WORD_SIZE-1:0]          add_sat;
    logic [WORD_SIZE-1:0]          acc_d;
    logic                          ev_pos, ev_neg;
    logic                          accept;

    always_comb begin
        prod_full  = $signed({{WORD_SIZE{bus.data_i[WORD_SIZE-1]}}, bus.data_i})
                   * $signed({{WORD_SIZE{bus.weight_i[WORD_SIZE-1]}}, bus.weight_i});
        prod_shift = prod_full >>> FRAC_BITS;
        hi_bits    = prod_shift[2*WORD_SIZE-1:WORD_SIZE-1];
        prod_pos   = !((&hi_bits) || !(|hi_bits)) && !prod_shift[2*WORD_SIZE-1];
        prod_neg   = !((&hi_bits) || !(|hi_bits)) &&  prod_shift[2*WORD_SIZE-1];
        prod_sat   = prod_pos ? SAT_MAX : (prod_neg ? SAT_MIN : prod_shift[WORD_SIZE-1:0]);

        sum     = {acc_q[WORD_SIZE-1], acc_q} + {prod_sat[WORD_SIZE-1], prod_sat};
        add_pos = (sum[WORD_SIZE:WORD_SIZE-1] == 2'b01);
        add_neg = (sum[WORD_SIZE:WORD_SIZE-1] == 2'b10);
        add_sat = add_pos ? SAT_MAX : (add_neg ? SAT_MIN : sum[WORD_SIZE-1:0]);

        // First beat loads the product; later beats report add saturation in preference to product saturation.
        if (state_q == S_IDLE) begin
            acc_d  = prod_sat;
            ev_pos = prod_pos;
            ev_neg = prod_neg;
        end else begin
            acc_d  = add_sat;
            ev_pos = add_pos || (!add_neg && prod_pos);
            ev_neg = add_neg || (!add_pos && prod_neg);
        end

        accept = bus.in_valid_i && in_ready_q && !abort_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_pulse_q <= 1'b0;
            unf_pulse_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
            unf_flag_q  <= 1'b0;
        end else begin
            ovf_pulse_q <= accept && ev_pos;
            unf_pulse_q <= accept && ev_neg;

            if (clear_flags_i) begin
                ovf_flag_q <= 1'b0;
                unf_flag_q <= 1'b0;
            end else begin
                if (accept && ev_pos && !unf_flag_q) ovf_flag_q <= 1'b1;
                if (accept && ev_neg && !ovf_flag_q) unf_flag_q <= 1'b1;
            end

            if (abort_i) begin
                state_q     <= S_IDLE;
                acc_q       <= '0;
                count_q     <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_ACCUM: begin
                        if (accept) begin
                            acc_q   <= acc_d;
                            count_q <= count_q + CNT_W'(1);
                            if (count_q == LAST_CNT) begin
                                state_q     <= S_DONE;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                                out_data_q  <= acc_d;
                            end else begin
                                state_q <= S_ACCUM;
                            end
                        end
                    end
                    S_DONE: begin
                        if (bus.out_ready_i) begin
                            state_q     <= S_IDLE;
                            acc_q       <= '0;
                            count_q     <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready_o   = in_ready_q;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_data_o   = out_data_q;
    assign overflow_o       = ovf_pulse_q;
    assign underflow_o      = unf_pulse_q;
    assign overflow_flag_o  = ovf_flag_q;
    assign underflow_flag_o = unf_flag_q;
endmodule

// File: tb/tb_mac_sat_sequencer.sv
// Directed bench for mac_sat_sequencer (16-bit Q8.8, 4 taps) with hand-computed expectations.
module tb_mac_sat_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic abort = 1'b0;
    logic clear_flags = 1'b0;
    logic ovf, unf, ovf_flag, unf_flag;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    mac_sat_sequencer_if #(.WORD_SIZE(16)) bus ();

    mac_sat_sequencer #(.WORD_SIZE(16), .INT_BITS(8), .NUM_TAPS(4)) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .abort_i          (abort),
        .clear_flags_i    (clear_flags),
        .bus              (bus),
        .overflow_o       (ovf),
        .underflow_o      (unf),
        .overflow_flag_o  (ovf_flag),
        .underflow_flag_o (unf_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] d, input logic [15:0] w);
        bus.in_valid_i = 1'b1;
        bus.data_i     = d;
        bus.weight_i   = w;
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [15:0] exp);
        check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        check({tag, "_data"},  32'(bus.out_data_o),  32'(exp));
        check({tag, "_inrdy"}, 32'(bus.in_ready_o),  32'd0);
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
        check({tag, "_idle_valid"}, 32'(bus.out_valid_o), 32'd0);
        check({tag, "_idle_inrdy"}, 32'(bus.in_ready_o),  32'd1);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.data_i      = '0;
        bus.weight_i    = '0;
        bus.out_ready_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_inrdy",  32'(bus.in_ready_o),  32'd1);
        check("rst_valid",  32'(bus.out_valid_o), 32'd0);
        check("rst_data",   32'(bus.out_data_o),  32'd0);
        check("rst_pulses", 32'({ovf, unf}),      32'd0);
        check("rst_flags",  32'({ovf_flag, unf_flag}), 32'd0);
        reset_n = 1'b1;
        step();

        // 1.0 x 2.0, four beats back-to-back -> 8.0
        for (int i = 0; i < 4; i++) begin
            feed(16'h0100, 16'h0200);
            check($sformatf("t1_pulse%0d", i), 32'({ovf, unf}), 32'd0);
        end
        check("t1_flags", 32'({ovf_flag, unf_flag}), 32'd0);
        take_result("t1", 16'h0800);

        // 127.0 x 1.0: saturates from beat 2 onward
        for (int i = 0; i < 4; i++) begin
            feed(16'h7F00, 16'h0100);
            check($sformatf("t2_ovf%0d", i), 32'(ovf), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("t2_unf%0d", i), 32'(unf), 32'd0);
        end
        check("t2_flags", 32'({ovf_flag, unf_flag}), 32'b10);
        take_result("t2", 16'h7FFF);
        pulse_clear();
        check("clr1_flags", 32'({ovf_flag, unf_flag}), 32'd0);

        // Op A: -127.0 x 1.0 underflows
        for (int i = 0; i < 4; i++) begin
            feed(16'h8100, 16'h0100);
            check($sformatf("opa_unf%0d", i), 32'(unf), (i == 0) ? 32'd0 : 32'd1);
        end
        check("opa_flags", 32'({ovf_flag, unf_flag}), 32'b01);
        take_result("opa", 16'h8000);

        // Op B without clear: overflow events do not set the overflow flag
        for (int i = 0; i < 4; i++) feed(16'h7F00, 16'h0100);
        check("opb_ovf_pulse", 32'(ovf), 32'd1);
        check("opb_flags", 32'({ovf_flag, unf_flag}), 32'b01);
        take_result("opb", 16'h7FFF);
        pulse_clear();
        check("clr2_flags", 32'({ovf_flag, unf_flag}), 32'd0);

        // Product saturation: 64.0 x 64.0 then zeros
        feed(16'h4000, 16'h4000);
        check("psat_ovf0", 32'(ovf), 32'd1);
        for (int i = 1; i < 4; i++) begin
            feed(16'h0000, 16'h0000);
            check($sformatf("psat_ovf%0d", i), 32'(ovf), 32'd0);
        end
        check("psat_flags", 32'({ovf_flag, unf_flag}), 32'b10);
        take_result("psat", 16'h7FFF);
        pulse_clear();
        check("clr3_flags", 32'({ovf_flag, unf_flag}), 32'd0);

        // DONE held with out_ready low while in_valid is asserted
        for (int i = 0; i < 4; i++) feed(16'h0100, 16'h0200);
        bus.in_valid_i = 1'b1;
        bus.data_i     = 16'h7F00;
        bus.weight_i   = 16'h7F00;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold_valid%0d", i), 32'(bus.out_valid_o), 32'd1);
            check($sformatf("hold_data%0d", i),  32'(bus.out_data_o),  32'h0800);
            check($sformatf("hold_inrdy%0d", i), 32'(bus.in_ready_o),  32'd0);
        end
        bus.in_valid_i = 1'b0;
        check("hold_flags", 32'({ovf_flag, unf_flag}), 32'd0);
        take_result("hold", 16'h0800);

        // Async reset mid-operation, right after an overflow beat
        feed(16'h7F00, 16'h0100);
        feed(16'h7F00, 16'h0100);
        check("prerst_ovf",  32'(ovf),      32'd1);
        check("prerst_flag", 32'(ovf_flag), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_inrdy", 32'(bus.in_ready_o),  32'd1);
        check("mrst_valid", 32'(bus.out_valid_o), 32'd0);
        check("mrst_data",  32'(bus.out_data_o),  32'd0);
        check("mrst_pulse", 32'({ovf, unf}),      32'd0);
        check("mrst_flags", 32'({ovf_flag, unf_flag}), 32'd0);
        #2;
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) feed(16'h0100, 16'h0100);
        take_result("postrst", 16'h0400);

        // Same-cycle clear beats a new event; then abort after tap 3
        feed(16'h7F00, 16'h0100);
        clear_flags = 1'b1;
        feed(16'h7F00, 16'h0100);
        clear_flags = 1'b0;
        check("clrwin_pulse", 32'(ovf),      32'd1);
        check("clrwin_flag",  32'(ovf_flag), 32'd0);
        feed(16'h7F00, 16'h0100);
        check("tap3_flag", 32'(ovf_flag), 32'd1);
        abort          = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.data_i     = 16'h0100;
        bus.weight_i   = 16'h0100;
        step();
        abort          = 1'b0;
        bus.in_valid_i = 1'b0;
        check("abort_valid", 32'(bus.out_valid_o), 32'd0);
        check("abort_inrdy", 32'(bus.in_ready_o),  32'd1);
        check("abort_pulse", 32'(ovf),             32'd0);
        check("abort_flags", 32'({ovf_flag, unf_flag}), 32'b10);
        for (int i = 0; i < 3; i++) begin
            feed(16'h0100, 16'h0100);
            check($sformatf("postab_notdone%0d", i), 32'(bus.out_valid_o), 32'd0);
        end
        feed(16'h0100, 16'h0100);
        check("postab_flags", 32'({ovf_flag, unf_flag}), 32'b10);
        take_result("postab", 16'h0400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
